// File: rtl/obuf_bank_write_serializer_pkg.sv
// Shared definitions for the OBUF bank write path: beat ratio derivation and FSM states.
// The shuffler derives its beat ratio with the same function so both sides agree.
package obuf_bank_write_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    function automatic int calc_ratio(input int ddr_bw, input int banks, input int dw);
        return ddr_bw / (banks * dw);
    endfunction

    function automatic int beat_idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/obuf_bank_write_serializer_beat_select.sv
// Holds one DDR word and steps through its beats.
// Each beat presents one element per bank on registered outputs.
module obuf_bank_write_serializer_beat_select
    import obuf_bank_write_serializer_pkg::*;
#(
    parameter int DDR_BANDWIDTH = 512,
    parameter int NUM_BANKS     = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int RATIO         = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load,
    input  logic [DDR_BANDWIDTH-1:0]        data_in,
    output logic                            beat_valid,
    output logic                            last_beat,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] bank_wr_data
);

    localparam int BW     = beat_idx_width(RATIO);
    localparam int LANE_W = NUM_BANKS * DATA_WIDTH;

    logic [DDR_BANDWIDTH-1:0] buf_p0;
    logic [BW-1:0]            beat_p0;
    logic                     advance;

    // Bank j takes element (j*RATIO + beat) of the bank-contiguous word.
    function automatic logic [LANE_W-1:0] select_beat(input logic [DDR_BANDWIDTH-1:0] word,
                                                      input int beat);
        logic [LANE_W-1:0] lanes;
        lanes = '0;
        for (int j = 0; j < NUM_BANKS; j++)
            lanes[j*DATA_WIDTH +: DATA_WIDTH] = word[(j*RATIO+beat)*DATA_WIDTH +: DATA_WIDTH];
        return lanes;
    endfunction

    assign advance = beat_valid && !last_beat;

    always_ff @(posedge clk) begin
        if (load)
            buf_p0 <= data_in;
    end

    // Beat 0 comes straight from data_in so it lands one cycle after the accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_valid   <= 1'b0;
            last_beat    <= 1'b0;
            beat_p0      <= '0;
            bank_wr_data <= '0;
        end else if (load) begin
            beat_valid   <= 1'b1;
            last_beat    <= (RATIO == 1);
            beat_p0      <= '0;
            bank_wr_data <= select_beat(data_in, 0);
        end else if (advance) begin
            beat_p0      <= beat_p0 + 1'b1;
            last_beat    <= (int'(beat_p0) + 2 == RATIO);
            bank_wr_data <= select_beat(buf_p0, int'(beat_p0) + 1);
        end else begin
            beat_valid   <= 1'b0;
            last_beat    <= 1'b0;
        end
    end

endmodule

// File: rtl/obuf_bank_write_serializer.sv
// Serialises shuffled DDR words into parallel OBUF bank writes, one job per start pulse.
// Top level holds the job FSM, input handshake, address counter and word counter.
module obuf_bank_write_serializer
    import obuf_bank_write_serializer_pkg::*;
#(
    parameter int DDR_BANDWIDTH = 512,
    parameter int NUM_BANKS     = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 10,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic [CNT_WIDTH-1:0]            num_words,
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    input  logic [DDR_BANDWIDTH-1:0]        data_in,
    output logic [NUM_BANKS-1:0]            bank_wr_en,
    output logic [ADDR_WIDTH-1:0]           bank_wr_addr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] bank_wr_data,
    output logic                            busy,
    output logic                            done
);

    localparam int RATIO = calc_ratio(DDR_BANDWIDTH, NUM_BANKS, DATA_WIDTH);

    state_t                state;
    logic [CNT_WIDTH-1:0]  num_words_q;
    logic [CNT_WIDTH-1:0]  words_acc;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic                  beat_valid;
    logic                  last_beat;
    logic                  words_left;
    logic                  accept;
    logic                  issue;

    // A new word may enter while the previous one shows its final beat: no bubble.
    assign words_left    = (words_acc != num_words_q);
    assign data_in_ready = (state == ST_RUN) && words_left && (!beat_valid || last_beat);
    assign accept        = data_in_valid && data_in_ready;
    assign issue         = accept || (beat_valid && !last_beat);
    assign bank_wr_en    = {NUM_BANKS{beat_valid}};

    obuf_bank_write_serializer_beat_select #(
        .DDR_BANDWIDTH (DDR_BANDWIDTH),
        .NUM_BANKS     (NUM_BANKS),
        .DATA_WIDTH    (DATA_WIDTH),
        .RATIO         (RATIO)
    ) u_beat_select (
        .clk          (clk),
        .reset        (reset),
        .load         (accept),
        .data_in      (data_in),
        .beat_valid   (beat_valid),
        .last_beat    (last_beat),
        .bank_wr_data (bank_wr_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            num_words_q  <= '0;
            words_acc    <= '0;
            addr_cnt     <= '0;
            bank_wr_addr <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (issue) begin
                bank_wr_addr <= addr_cnt;
                addr_cnt     <= addr_cnt + 1'b1;
            end
            if (accept)
                words_acc <= words_acc + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_words_q <= num_words;
                        words_acc   <= '0;
                        addr_cnt    <= base_addr;
                        busy        <= 1'b1;
                        if (num_words == '0) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (beat_valid && last_beat && !words_left) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obuf_bank_write_serializer.sv
// Scoreboard bench for obuf_bank_write_serializer: the driver queues expected beats on each accept,
// and a negedge monitor pops and compares every bank write and done pulse.
module tb_obuf_bank_write_serializer;

    localparam int DDR = 512;
    localparam int NB  = 8;
    localparam int DW  = 8;
    localparam int AW  = 10;
    localparam int CW  = 16;
    localparam int R   = DDR / (NB * DW);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [CW-1:0]    num_words;
    logic             data_in_valid;
    logic             data_in_ready;
    logic [DDR-1:0]   data_in;
    logic [NB-1:0]    bank_wr_en;
    logic [AW-1:0]    bank_wr_addr;
    logic [NB*DW-1:0] bank_wr_data;
    logic             busy;
    logic             done;

    obuf_bank_write_serializer #(
        .DDR_BANDWIDTH (DDR),
        .NUM_BANKS     (NB),
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .num_words     (num_words),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .data_in       (data_in),
        .bank_wr_en    (bank_wr_en),
        .bank_wr_addr  (bank_wr_addr),
        .bank_wr_data  (bank_wr_data),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [NB*DW-1:0] data;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         mon_e;
    int            checks = 0;
    int            errors = 0;
    int            cycle = 0;
    int            job_writes = 0;
    int            first_wr = 0;
    int            last_wr = 0;
    int            done_cnt = 0;
    int            start_cyc = 0;
    int            job_n = 0;
    logic [AW-1:0] model_addr;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic logic [DDR-1:0] gen_word(input bit counting);
        logic [DDR-1:0] w;
        for (int k = 0; k < DDR / 32; k++) w[k*32 +: 32] = $urandom;
        if (counting)
            for (int k = 0; k < DDR / 8; k++) w[k*8 +: 8] = 8'(k);
        return w;
    endfunction

    // Reference: bank j on beat b writes element j*R+b; addresses run on from base_addr mod 2^AW.
    task automatic push_word(input logic [DDR-1:0] w);
        beat_t e;
        for (int b = 0; b < R; b++) begin
            for (int j = 0; j < NB; j++) e.data[j*DW +: DW] = w[(j*R+b)*DW +: DW];
            e.addr     = model_addr;
            model_addr = model_addr + 1'b1;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bank_wr_en != '0) begin
                check("wr_en_all_banks", 64'(bank_wr_en), 64'({NB{1'b1}}));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write addr=%0h data=%0h required=no write", bank_wr_addr, bank_wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 64'(bank_wr_addr), 64'(mon_e.addr));
                    check("wr_data", 64'(bank_wr_data), 64'(mon_e.data));
                end
                if (job_writes == 0) first_wr = cycle;
                last_wr = cycle;
                job_writes++;
            end
            if (done) begin
                done_cnt++;
                check("done_pending_beats", 64'(exp_q.size()), 64'd0);
                if (job_n == 0) check("done_latency_empty_job", 64'(cycle), 64'(start_cyc + 1));
                else            check("done_after_last_beat", 64'(cycle), 64'(last_wr + 1));
            end
            check("ready_implies_busy", 64'(data_in_ready & ~busy), 64'd0);
        end
    end

    // mode 0: valid held high; 1: random valid; 2: one cycle high, nine low.
    task automatic run_job(input logic [AW-1:0] base, input int n, input int mode,
                           input bit poke, input bit counting);
        int             acc = 0;
        int             it = 0;
        bit             poked = 0;
        bit             v;
        logic [DDR-1:0] w;
        job_writes = 0;
        done_cnt   = 0;
        job_n      = n;
        model_addr = base;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        num_words = CW'(n);
        start_cyc = cycle;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        num_words = CW'($urandom);
        w = gen_word(counting);
        while (done_cnt == 0 && it < 3000) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = 1'($urandom_range(0, 1));
            else                v = (it % 10 == 0);
            data_in_valid = v;
            data_in       = w;
            if (poke && !poked && acc == 2) begin
                start     = 1'b1;
                base_addr = ~base;
                num_words = 16'd9;
                poked     = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (v && data_in_ready) begin
                push_word(w);
                acc++;
                w = gen_word(counting);
            end
            @(posedge clk); #1;
            it++;
        end
        start         = 1'b0;
        data_in_valid = 1'b0;
        if (it >= 3000) begin
            checks++;
            errors++;
            $display("FAIL job_timeout base=%0h n=%0d accepted=%0d required done pulse", base, n, acc);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("accepted_words", 64'(acc), 64'(n));
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("write_cycles", 64'(job_writes), 64'(n * R));
        check("busy_cleared", 64'(busy), 64'd0);
    endtask

    task automatic reset_mid_job();
        int             k = 0;
        logic [DDR-1:0] w;
        job_writes = 0;
        done_cnt   = 0;
        job_n      = 3;
        model_addr = 10'h100;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = 10'h100;
        num_words = 16'd3;
        start_cyc = cycle;
        @(posedge clk); #1;
        start = 1'b0;
        w = gen_word(0);
        data_in_valid = 1'b1;
        while (k < 200) begin
            data_in = w;
            @(negedge clk);
            if (data_in_ready) begin
                push_word(w);
                w = gen_word(0);
            end
            if (bank_wr_en != '0 && bank_wr_addr == 10'h10B) break;
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL reset_job_timeout actual=no beat 3 of word 1 required=write at 10b");
        end
        reset         = 1'b1;
        data_in_valid = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        check("reset_mid_wr_en", 64'(bank_wr_en), 64'd0);
        check("reset_mid_busy", 64'(busy), 64'd0);
        check("reset_mid_ready", 64'(data_in_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("reset_mid_no_done", 64'(done_cnt), 64'd0);
        check("reset_mid_no_writes", 64'(bank_wr_en), 64'd0);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        base_addr     = '0;
        num_words     = '0;
        data_in_valid = 1'b0;
        data_in       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_wr_en", 64'(bank_wr_en), 64'd0);
        check("reset_wr_addr", 64'(bank_wr_addr), 64'd0);
        check("reset_wr_data", 64'(bank_wr_data), 64'd0);
        check("reset_ready", 64'(data_in_ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Data offered before any start must not be consumed.
        data_in_valid = 1'b1;
        data_in       = gen_word(0);
        @(negedge clk);
        check("ready_before_start", 64'(data_in_ready), 64'd0);
        @(posedge clk); #1;
        data_in_valid = 1'b0;

        run_job(10'h010, 1, 0, 0, 1);
        run_job(10'h020, 4, 0, 0, 0);
        check("stream_span", 64'(last_wr - first_wr + 1), 64'(4 * R));
        run_job(10'h040, 3, 2, 0, 0);
        run_job(10'h3FC, 1, 0, 0, 1);
        run_job(10'h3FE, 2, 1, 0, 0);
        run_job(10'h123, 0, 0, 0, 0);
        run_job(10'h200, 4, 1, 1, 0);
        reset_mid_job();
        run_job(10'h300, 2, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            run_job(AW'($urandom), $urandom_range(1, 5), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
